// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder, one operand bit per clock, LSB first.
// Optional subtract mode and signed overflow flag behind SERIAL_ADDER_SUB_EN.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] ps_shift;
    logic             fa_s, fa_c;
    logic             sub_in;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
    assign ovf    = ovf_q;
`else
    assign sub_in = 1'b0;
`endif

    full_adder u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ps_d     = ps_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        ps_shift = ps_q >> 1;
        ps_shift[WIDTH-1] = fa_s;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub_in ? ~b : b;
                    carry_d = sub_in ? 1'b1 : cin;
                    ps_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                ps_d    = ps_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // carry_q here is the carry into the MSB
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = ps_shift;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=4).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] ai, bi;
    logic         cini;
    logic         ready, busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (ai),
        .b     (bi),
        .cin   (cini),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
        .ovf   (ovf),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // waits for done; checks busy and a stable sum meanwhile
    task automatic wait_done(input logic [W-1:0] hold, output int lat);
        lat = 0;
        while (!done && lat < 4 * W) begin
            tick();
            lat++;
            if (!done) begin
                check("run_busy", busy, 1);
                check("run_hold", sum, hold);
            end
        end
        check("done_seen", done, 1);
    endtask

    task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic c, input logic s,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo);
        int lat;
        logic [W-1:0] hold;
        ai = av; bi = bv; cini = c; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        hold = sum;
        tick();
        start = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_ready", ready, 0);
        wait_done(hold, lat);
        check("latency", lat, W);
        check("sum", sum, es);
        check("cout", cout, ec);
`ifdef SERIAL_ADDER_SUB_EN
        check("ovf", ovf, eo);
`else
        if (s || eo) $display("note: sub vector skipped");
`endif
        tick();
        check("done_1cyc", done, 0);
        check("idle_ready", ready, 1);
        check("sum_held", sum, es);
        check("cout_held", cout, ec);
    endtask

    initial begin
        int lat, lat2, nd;
        rst_n = 1'b0; start = 1'b0; ai = '0; bi = '0; cini = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        #12;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        do_add(4'h5, 4'h3, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0);
        do_add(4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        do_add(4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
        do_add(4'h5, 4'h3, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0);

        // reset mid-run
        ai = 4'h5; bi = 4'h3; cini = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_ready", ready, 1);
        check("mr_busy", busy, 0);
        check("mr_sum", sum, 0);
        check("mr_cout", cout, 0);
        #1 rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done) nd++;
        end
        check("mr_no_done", nd, 0);

        // start held high: back-to-back
        ai = 4'h2; bi = 4'h2; cini = 1'b0; start = 1'b1;
        tick();
        wait_done(sum, lat);
        check("b2b_lat1", lat, W);
        check("b2b_sum1", sum, 4'h4);
        ai = 4'h7; bi = 4'h1;
        tick();
        check("b2b_busy", busy, 1);
        check("b2b_nodone", done, 0);
        wait_done(4'h4, lat2);
        start = 1'b0;
        check("b2b_gap", lat2 + 1, W + 1);
        check("b2b_sum2", sum, 4'h8);
        check("b2b_cout2", cout, 0);
        tick();

        // start pulse injected during RUN
        ai = 4'h1; bi = 4'h1; cini = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ai = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4'h8, lat);
        check("inj_lat", lat + 2, W);
        check("inj_sum", sum, 4'h2);
        nd = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done) nd++;
        end
        check("inj_no_extra", nd, 0);

        // operands scrambled during RUN
        ai = 4'h9; bi = 4'h8; cini = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 4 * W) begin
            ai = 4'($urandom); bi = 4'($urandom); cini = 1'($urandom);
            tick();
            lat++;
        end
        check("stab_lat", lat, W);
        check("stab_sum", sum, 4'h2);
        check("stab_cout", cout, 1);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        do_add(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
        do_add(4'h8, 4'h1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1);
        do_add(4'h5, 4'h3, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that time-shares a single instantiated full_adder across a WIDTH-bit operand pair, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It serves as the low-area alternative to the ripple four-bit adder in the FourBitAdder lab datapath.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 1 to 32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
ready  output  1  controller can accept start (state IDLE or DONE)
busy  output  1  addition in progress (state RUN)
done  output  1  one-cycle completion pulse (state DONE)
sum  output  WIDTH  registered result; held until the next completion
cout  output  1  registered final carry; held until the next completion

Behaviour:
- Reset: rst_n=0 forces the following immediately, regardless of clk.
  - State goes to IDLE.
  - ready=1, busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flip-flop and counter clear to 0.
  - A reset during RUN abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE. Outputs are decoded from the state: ready=(IDLE|DONE), busy=RUN, done=DONE.
- IDLE/DONE with start=1 at edge E0:
  - Capture a and b into shift registers, and cin into the carry flip-flop.
  - Clear the counter and go to RUN.
- IDLE/DONE with start=0: DONE returns to IDLE; IDLE holds.
- RUN, each edge:
  - Drive the full_adder with x=A[0], y=B[0], z=carry.
  - Shift the S output into the MSB of the partial-sum register, which shifts right.
  - Load carry with the C output.
  - Shift A and B right by one; increment the counter.
- At edge E_WIDTH (counter = WIDTH-1 before the edge):
  - Load the final partial sum into sum and the final carry into cout.
  - Go to DONE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after the accepting edge. Throughput is one add per WIDTH+1 cycles when start is held high.
- Back-to-back: start=1 while in DONE is accepted. done is high for exactly that one cycle; the next done follows WIDTH cycles later.
- start while in RUN is ignored and not queued.
- a, b and cin changes after E0 have no effect on the operation in flight.
- sum and cout change only on the edge entering DONE, or on reset. They are stable across RUN.
- WIDTH=1: RUN lasts one cycle; behaviour is otherwise identical.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag in the base configuration.
- Counter width: $clog2(WIDTH), minimum 1 bit.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input sub (1 bit), captured on the accepting edge.
  - When sub=1, B is loaded bitwise inverted and the carry is loaded with 1, overriding cin. The result is sum = a - b mod 2^WIDTH, and cout=1 means no borrow.
  - Adds output ovf (1 bit), registered with sum. It reports two's-complement signed overflow, equal to the carry into the MSB XOR the carry out of the MSB. ovf resets to 0.
- Undefined: neither port exists and behaviour is exactly as in Behaviour.

Test Plan:
1. Reset mid-RUN: WIDTH=4, start a=4'h5 b=4'h3 cin=0; assert rst_n=0 after 2 RUN cycles -> immediately ready=1, busy=0, sum=0, cout=0; no done pulse after release.
2. Basic add: a=4'h5 b=4'h3 cin=0, start for one cycle -> busy=1 for 4 cycles; done=1 for 1 cycle with sum=4'h8, cout=0; values held afterwards.
3. Carry chain: a=4'hF b=4'h0 cin=1 -> sum=4'h0, cout=1. a=4'hF b=4'hF cin=1 -> sum=4'hF, cout=1.
4. Handshake: start held high continuously with a=4'h2 b=4'h2, then 4'h7/4'h1 -> done pulses 5 cycles apart, results 4'h4 then 4'h8. A start pulse injected during RUN produces no extra done.
5. Operand stability: change a/b every cycle during RUN -> result equals the operands captured at E0.
6. With SERIAL_ADDER_SUB_EN, sub=1:
   - a=4'h3 b=4'h5 -> sum=4'hE, cout=0, ovf=0.
   - a=4'h8 b=4'h1 -> sum=4'h7, cout=1, ovf=1.
